// File: rtl/freq_set_pkg.sv
// Shared types and helpers for the push-button BCD frequency setter.
package freq_set_pkg;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, REPEAT} fs_state_t;
    typedef enum {NONE, UP, DN} fs_dir_t;

    localparam int BCD_W  = 4;
    localparam int TCNT_W = 16;

    // True when the low n digits of v are all 9s or all 0s (n is at most 6).
    function automatic logic bcd_is_limit(input logic [23:0] v, input int n);
        logic nines;
        logic zeros;
        nines = 1'b1;
        zeros = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < n) begin
                if (v[i*4 +: 4] != 4'd9) nines = 1'b0;
                if (v[i*4 +: 4] != 4'd0) zeros = 1'b0;
            end
        end
        return nines | zeros;
    endfunction

endpackage

// File: rtl/bcd_freq_setter_digit.sv
// bcd_updown_digit: one BCD digit register with ripple carry/borrow for +/-1 steps.
module bcd_updown_digit
    import freq_set_pkg::*;
#(
    parameter logic [BCD_W-1:0] INIT = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             carry_i,
    input  logic             borrow_i,
    output logic [BCD_W-1:0] digit_o,
    output logic [BCD_W-1:0] digit_next_o,
    output logic             carry_o,
    output logic             borrow_o
);

    assign carry_o  = carry_i  && (digit_o == 4'd9);
    assign borrow_o = borrow_i && (digit_o == 4'd0);

    always_comb begin
        digit_next_o = digit_o;
        if (en_i && carry_i)
            digit_next_o = (digit_o == 4'd9) ? 4'd0 : digit_o + 4'd1;
        else if (en_i && borrow_i)
            digit_next_o = (digit_o == 4'd0) ? 4'd9 : digit_o - 4'd1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) digit_o <= INIT;
        else         digit_o <= digit_next_o;
    end

endmodule

// File: rtl/bcd_freq_setter.sv
// Up/down push-buttons to N-digit BCD setpoint with debounce, hold and auto-repeat, timed in ticks.
// Define BCD_WRAP_EN to wrap 999<->000 instead of saturating.
//
// state    | meaning
// IDLE     | no direction pressed
// DEBOUNCE | direction held, waiting DEBOUNCE_TICKS for the first step
// HOLD     | first step done, waiting HOLD_TICKS before auto-repeat
// REPEAT   | stepping every REPEAT_TICKS while held
module bcd_freq_setter
    import freq_set_pkg::*;
#(
    parameter int FREQ_DIGITS_N  = 3,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int HOLD_TICKS     = 500,
    parameter int REPEAT_TICKS   = 100,
    parameter logic [4*FREQ_DIGITS_N-1:0] INIT_BCD = 'h100
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       tick_i,
    input  logic                       btn_up_i,
    input  logic                       btn_dn_i,
    output logic [4*FREQ_DIGITS_N-1:0] digits_o,
    output logic                       step_o,
    output logic                       at_limit_o
);

    localparam int DW = BCD_W * FREQ_DIGITS_N;
    localparam logic INIT_LIMIT = bcd_is_limit(24'(INIT_BCD), FREQ_DIGITS_N);
    localparam logic [TCNT_W-1:0] DEB_T = TCNT_W'(DEBOUNCE_TICKS);
    localparam logic [TCNT_W-1:0] HLD_T = TCNT_W'(HOLD_TICKS);
    localparam logic [TCNT_W-1:0] REP_T = TCNT_W'(REPEAT_TICKS);

    logic [1:0]        up_sync;
    logic [1:0]        dn_sync;
    fs_dir_t           dir;
    fs_dir_t           dir_q, dir_n;
    fs_state_t         state_q, state_n;
    logic [TCNT_W-1:0] tcnt_q, tcnt_n, tcnt_inc;
    logic              step_req;
    logic              step_en;
    logic [FREQ_DIGITS_N:0] carry;
    logic [FREQ_DIGITS_N:0] borrow;
    logic [DW-1:0]     digits_next;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            up_sync <= '0;
            dn_sync <= '0;
        end else begin
            up_sync <= {up_sync[0], btn_up_i};
            dn_sync <= {dn_sync[0], btn_dn_i};
        end
    end

    always_comb begin
        dir = NONE;
        if (up_sync[1] && !dn_sync[1])      dir = UP;
        else if (dn_sync[1] && !up_sync[1]) dir = DN;
    end

    // A tick "reaches" the threshold on the tick that completes the count.
    assign tcnt_inc = tcnt_q + TCNT_W'(1);

    always_comb begin
        state_n  = state_q;
        dir_n    = dir_q;
        tcnt_n   = tick_i ? tcnt_inc : tcnt_q;
        step_req = 1'b0;
        case (state_q)
            IDLE: begin
                tcnt_n = '0;
                if (dir != NONE) begin
                    state_n = DEBOUNCE;
                    dir_n   = dir;
                end
            end
            DEBOUNCE: begin
                if (dir != dir_q) begin
                    state_n = IDLE;
                    tcnt_n  = '0;
                end else if (tick_i && tcnt_inc == DEB_T) begin
                    step_req = 1'b1;
                    state_n  = HOLD;
                    tcnt_n   = '0;
                end
            end
            HOLD: begin
                if (dir != dir_q) begin
                    state_n = IDLE;
                    tcnt_n  = '0;
                end else if (tick_i && tcnt_inc == HLD_T) begin
                    step_req = 1'b1;
                    state_n  = REPEAT;
                    tcnt_n   = '0;
                end
            end
            REPEAT: begin
                if (dir != dir_q) begin
                    state_n = IDLE;
                    tcnt_n  = '0;
                end else if (tick_i && tcnt_inc == REP_T) begin
                    step_req = 1'b1;
                    tcnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                tcnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            dir_q   <= NONE;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_n;
            dir_q   <= dir_n;
            tcnt_q  <= tcnt_n;
        end
    end

    assign carry[0]  = step_req && (dir_q == UP);
    assign borrow[0] = step_req && (dir_q == DN);

    // A ripple out of the top digit means the setpoint is at its limit.
`ifdef BCD_WRAP_EN
    assign step_en = step_req;
`else
    assign step_en = step_req && !carry[FREQ_DIGITS_N] && !borrow[FREQ_DIGITS_N];
`endif

    for (genvar g = 0; g < FREQ_DIGITS_N; g++) begin : g_digit
        bcd_updown_digit #(
            .INIT(INIT_BCD[g*BCD_W +: BCD_W])
        ) u_digit (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .en_i        (step_en),
            .carry_i     (carry[g]),
            .borrow_i    (borrow[g]),
            .digit_o     (digits_o[g*BCD_W +: BCD_W]),
            .digit_next_o(digits_next[g*BCD_W +: BCD_W]),
            .carry_o     (carry[g+1]),
            .borrow_o    (borrow[g+1])
        );
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            step_o     <= 1'b0;
            at_limit_o <= INIT_LIMIT;
        end else begin
            step_o     <= step_en;
            at_limit_o <= bcd_is_limit(24'(digits_next), FREQ_DIGITS_N);
        end
    end

endmodule

// File: tb/tb_bcd_freq_setter.sv
// Directed testbench for bcd_freq_setter: debounce, hold, repeat, carry/borrow, limits, reset.
module tb_bcd_freq_setter;
    import freq_set_pkg::*;

    logic clk, reset, tick;
    logic up_a, dn_a, up_b, dn_b, up_c, dn_c;
    logic [11:0] dig_a, dig_b, dig_c;
    logic step_a, step_b, step_c, lim_a, lim_b, lim_c;
    int n_vec, n_err, cnt_a, base;

    bcd_freq_setter #(.FREQ_DIGITS_N(3), .DEBOUNCE_TICKS(3), .HOLD_TICKS(10),
                      .REPEAT_TICKS(2), .INIT_BCD(12'h100)) dut_a (
        .clk_i(clk), .reset_i(reset), .tick_i(tick), .btn_up_i(up_a), .btn_dn_i(dn_a),
        .digits_o(dig_a), .step_o(step_a), .at_limit_o(lim_a));

    bcd_freq_setter #(.FREQ_DIGITS_N(3), .DEBOUNCE_TICKS(3), .HOLD_TICKS(10),
                      .REPEAT_TICKS(2), .INIT_BCD(12'h199)) dut_b (
        .clk_i(clk), .reset_i(reset), .tick_i(tick), .btn_up_i(up_b), .btn_dn_i(dn_b),
        .digits_o(dig_b), .step_o(step_b), .at_limit_o(lim_b));

    bcd_freq_setter #(.FREQ_DIGITS_N(3), .DEBOUNCE_TICKS(3), .HOLD_TICKS(10),
                      .REPEAT_TICKS(2), .INIT_BCD(12'h998)) dut_c (
        .clk_i(clk), .reset_i(reset), .tick_i(tick), .btn_up_i(up_c), .btn_dn_i(dn_c),
        .digits_o(dig_c), .step_o(step_c), .at_limit_o(lim_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            repeat (4) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    always @(negedge clk) if (step_a === 1'b1) cnt_a <= cnt_a + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns on the negedge just after the n-th tick has been sampled.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (tick !== 1'b1);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cnt_a = 0; base = 0;
        reset = 1'b1;
        {up_a, dn_a, up_b, dn_b, up_c, dn_c} = '0;
        repeat (2) @(negedge clk);
        check("rst_dig_a", 32'(dig_a), 32'h100);
        check("rst_step_a", 32'(step_a), 32'h0);
        check("rst_lim_a", 32'(lim_a), 32'h0);
        check("rst_dig_b", 32'(dig_b), 32'h199);
        check("rst_dig_c", 32'(dig_c), 32'h998);
        check("rst_lim_c", 32'(lim_c), 32'h0);
        reset = 1'b0;

        // short press: only two ticks, no step
        wait_ticks(1);
        base = cnt_a;
        up_a = 1'b1;
        wait_ticks(2);
        up_a = 1'b0;
        wait_ticks(3);
        check("short_steps", 32'(cnt_a - base), 32'd0);
        check("short_dig", 32'(dig_a), 32'h100);
        // three ticks: exactly one step
        wait_ticks(1);
        base = cnt_a;
        up_a = 1'b1;
        wait_ticks(3);
        check("deb_dig", 32'(dig_a), 32'h101);
        check("deb_step", 32'(step_a), 32'h1);
        up_a = 1'b0;
        wait_ticks(3);
        check("deb_steps", 32'(cnt_a - base), 32'd1);

        // long hold: steps at 3, 13, 15, 17, 19, 21 ticks
        do_reset();
        wait_ticks(1);
        base = cnt_a;
        up_a = 1'b1;
        wait_ticks(2);
        check("rep_t2", 32'(dig_a), 32'h100);
        wait_ticks(1);
        check("rep_t3", 32'(dig_a), 32'h101);
        check("rep_t3_step", 32'(step_a), 32'h1);
        wait_ticks(9);
        check("rep_t12", 32'(dig_a), 32'h101);
        wait_ticks(1);
        check("rep_t13", 32'(dig_a), 32'h102);
        check("rep_t13_step", 32'(step_a), 32'h1);
        wait_ticks(1);
        check("rep_t14_step", 32'(step_a), 32'h0);
        wait_ticks(7);
        check("rep_t21", 32'(dig_a), 32'h106);
        up_a = 1'b0;
        wait_ticks(3);
        check("rep_steps", 32'(cnt_a - base), 32'd6);
        check("rep_final", 32'(dig_a), 32'h106);

        // reset while auto-repeating
        do_reset();
        wait_ticks(1);
        up_a = 1'b1;
        wait_ticks(15);
        check("mid_dig", 32'(dig_a), 32'h103);
        check("mid_state", 32'(dut_a.state_q), 32'(REPEAT));
        check("mid_step", 32'(step_a), 32'h1);
        reset = 1'b1;
        up_a = 1'b0;
        #1;
        check("async_dig", 32'(dig_a), 32'h100);
        check("async_step", 32'(step_a), 32'h0);
        check("async_state", 32'(dut_a.state_q), 32'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_state", 32'(dut_a.state_q), 32'(IDLE));

        // both buttons: no direction
        wait_ticks(1);
        base = cnt_a;
        up_a = 1'b1;
        dn_a = 1'b1;
        wait_ticks(6);
        check("both_steps", 32'(cnt_a - base), 32'd0);
        check("both_state", 32'(dut_a.state_q), 32'(IDLE));
        up_a = 1'b0;
        dn_a = 1'b0;
        wait_ticks(2);

        // switch up -> down while in HOLD
        up_a = 1'b1;
        wait_ticks(5);
        check("sw_dig_up", 32'(dig_a), 32'h101);
        check("sw_hold", 32'(dut_a.state_q), 32'(HOLD));
        up_a = 1'b0;
        dn_a = 1'b1;
        repeat (3) @(negedge clk);
        check("sw_idle", 32'(dut_a.state_q), 32'(IDLE));
        @(negedge clk);
        check("sw_deb", 32'(dut_a.state_q), 32'(DEBOUNCE));
        wait_ticks(2);
        check("sw_t2", 32'(dig_a), 32'h101);
        wait_ticks(1);
        check("sw_dn_dig", 32'(dig_a), 32'h100);
        check("sw_dn_step", 32'(step_a), 32'h1);
        dn_a = 1'b0;

        // carry and borrow across two digits
        wait_ticks(1);
        up_b = 1'b1;
        wait_ticks(3);
        check("carry_dig", 32'(dig_b), 32'h200);
        check("carry_step", 32'(step_b), 32'h1);
        check("carry_lim", 32'(lim_b), 32'h0);
        up_b = 1'b0;
        wait_ticks(2);
        dn_b = 1'b1;
        wait_ticks(3);
        check("borrow_dig", 32'(dig_b), 32'h199);
        check("borrow_step", 32'(step_b), 32'h1);
        dn_b = 1'b0;

        // upper limit
        wait_ticks(1);
        up_c = 1'b1;
        wait_ticks(3);
        check("lim_dig", 32'(dig_c), 32'h999);
        check("lim_step", 32'(step_c), 32'h1);
        check("lim_flag", 32'(lim_c), 32'h1);
        wait_ticks(10);
`ifdef BCD_WRAP_EN
        check("wrap_dig", 32'(dig_c), 32'h000);
        check("wrap_step", 32'(step_c), 32'h1);
        check("wrap_flag", 32'(lim_c), 32'h1);
        wait_ticks(2);
        check("wrap_next", 32'(dig_c), 32'h001);
        check("wrap_next_flag", 32'(lim_c), 32'h0);
`else
        check("sat_dig", 32'(dig_c), 32'h999);
        check("sat_step", 32'(step_c), 32'h0);
        check("sat_flag", 32'(lim_c), 32'h1);
        wait_ticks(2);
        check("sat_next", 32'(dig_c), 32'h999);
        check("sat_next_step", 32'(step_c), 32'h0);
`endif
        up_c = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
